imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//   Shares one single-port synchronous program RAM between the CPU fetch
//   port and the loader port (UART boot / debug). One access per cycle.
//   Grants are combinational. The read-data owner is tracked by registered
//   tags, so a read granted in cycle T returns data in cycle T+1 while a new
//   access is already being granted in T+1.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   f_req, f_addr                fetch read request and word address
//   f_gnt, f_rvalid, f_rdata     fetch grant, read-data valid, read data
//   l_req, l_we, l_addr, l_wdata loader request, write flag, address, data
//   l_lock                       program-load lock, blocks fetch while high
//   l_gnt, l_rvalid, l_rdata     loader grant, read-data valid, read data
//   mem_addr, mem_we, mem_din    RAM address, write enable, write data
//   mem_dout                     RAM read data, one cycle after the address
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic {F_NONE, F_FETCH}  f_tag_t;
    typedef enum logic {L_NONE, L_LOADER} l_tag_t;

    // High when the loader owned the most recent grant.
    logic   last_loader;
    f_tag_t f_tag;
    l_tag_t l_tag;

    logic f_elig;
    logic l_elig;

    // Grant decision: fetch is only eligible while the lock is low; on a
    // tie the requester that did not win most recently is served.
    always_comb begin
        f_elig = f_req && !l_lock && !rst;
        l_elig = l_req && !rst;
        f_gnt  = 1'b0;
        l_gnt  = 1'b0;
        if (f_elig && l_elig) begin
            f_gnt = last_loader;
            l_gnt = !last_loader;
        end else begin
            f_gnt = f_elig;
            l_gnt = l_elig;
        end
    end

    // An idle cycle still presents the fetch address; only a write needs
    // mem_we, and that can only come from a loader grant.
    assign mem_addr = l_gnt ? l_addr : f_addr;
    assign mem_we   = l_gnt && l_we;
    assign mem_din  = l_wdata;

    // Owner tags and round-robin pointer. Tags are rewritten every cycle,
    // so a new grant in T+1 sets up T+2 without touching the T+1 return.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_loader <= 1'b1;
            f_tag       <= F_NONE;
            l_tag       <= L_NONE;
        end else begin
            if (f_gnt) begin
                last_loader <= 1'b0;
            end else if (l_gnt) begin
                last_loader <= 1'b1;
            end
            f_tag <= f_gnt ? F_FETCH : F_NONE;
            l_tag <= (l_gnt && !l_we) ? L_LOADER : L_NONE;
        end
    end

    // Gating with rst suppresses a return for a read granted in the cycle
    // just before reset; the tag itself is cleared at the end of that cycle.
    assign f_rvalid = (f_tag == F_FETCH) && !rst;
    assign l_rvalid = (l_tag == L_LOADER) && !rst;
    assign f_rdata  = f_rvalid ? mem_dout : '0;
    assign l_rdata  = l_rvalid ? mem_dout : '0;

endmodule
